// File: rtl/pc_fetch_ctrl_32_if.sv
// Instruction-memory fetch bus: req/addr from the fetch controller, ack/rdata from imem.
interface pc_fetch_ctrl_32_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl_32.sv
// PC sequencing and req/ack instruction fetch for the MIPS core.
// Optional retire counter enabled by defining PC_RETIRE_CNT_EN.
module pc_fetch_ctrl_32 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  pc_fetch_ctrl_32_if.master        imem,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_off,
  input  logic                      jump,
  input  logic [25:0]               jump_target,
  input  logic                      jr,
  input  logic [31:0]               jr_addr,
  input  logic                      exc,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic                      misalign_err,
  output logic                      timeout_err
`ifdef PC_RETIRE_CNT_EN
  ,
  output logic [31:0]               retire_cnt
`endif
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;
  logic [31:0]     sel_pc;
  logic [31:0]     next_pc;
  logic            sel_misaligned;
`ifdef PC_RETIRE_CNT_EN
  logic [31:0]     ret_q, ret_d;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect priority: exc > jr > jump > branch > sequential.
  always_comb begin
    sel_pc = pc_plus4;
    if (exc) begin
      sel_pc = EXC_VECTOR;
    end else if (jr) begin
      sel_pc = jr_addr;
    end else if (jump) begin
      sel_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      sel_pc = pc_plus4 + (branch_off << 2);
    end
  end

  assign sel_misaligned = |sel_pc[1:0];
  assign next_pc        = sel_misaligned ? EXC_VECTOR : sel_pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    to_d    = to_q;
`ifdef PC_RETIRE_CNT_EN
    ret_d   = ret_q;
`endif
    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        // An ack in the last allowed cycle still beats the timeout.
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          cnt_d   = '0;
          state_d = StExec;
        end else if (cnt_q == CntLast) begin
          pc_d    = EXC_VECTOR;
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = StFetch;
          if (sel_misaligned) begin
            mis_d = 1'b1;
          end
`ifdef PC_RETIRE_CNT_EN
          ret_d = ret_q + 32'd1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef PC_RETIRE_CNT_EN
      ret_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
`ifdef PC_RETIRE_CNT_EN
      ret_q   <= ret_d;
`endif
    end
  end

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == StExec);
  assign pc             = pc_q;
  assign misalign_err   = mis_q;
  assign timeout_err    = to_q;
`ifdef PC_RETIRE_CNT_EN
  assign retire_cnt     = ret_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl_32.sv
// Randomized self-checking bench for pc_fetch_ctrl_32 against a transaction-level PC model.
// Define PC_RETIRE_CNT_EN to also check the retire counter.
module tb_pc_fetch_ctrl_32;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EV  = 32'h0000_0080;
  localparam int          ATO = 16;

  typedef struct packed {
    logic        exc;
    logic        jr;
    logic [31:0] jr_addr;
    logic        jump;
    logic [25:0] tgt;
    logic        br;
    logic [31:0] off;
  } redir_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic        timeout_err;
`ifdef PC_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  pc_fetch_ctrl_32_if bus ();

  pc_fetch_ctrl_32 #(
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .ACK_TIMEOUT  (ATO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .exc          (exc),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
`ifdef PC_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_pc;
  logic        m_mis;
  logic        m_to;
  logic [31:0] m_ret;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic redir_t no_redir();
    redir_t r;
    r = '0;
    return r;
  endfunction

  function automatic redir_t rand_redir();
    redir_t r;
    r.exc     = ($urandom_range(0, 15) == 0);
    r.jr      = ($urandom_range(0, 7) == 0);
    r.jr_addr = $urandom;
    if ($urandom_range(0, 3) != 0) r.jr_addr[1:0] = 2'b00;
    r.jump    = ($urandom_range(0, 5) == 0);
    r.tgt     = 26'($urandom);
    r.br      = ($urandom_range(0, 3) == 0);
    r.off     = 32'($urandom_range(0, 64)) - 32'd32;
    return r;
  endfunction

  task automatic drive_redir(input redir_t r);
    exc          = r.exc;
    jr           = r.jr;
    jr_addr      = r.jr_addr;
    jump         = r.jump;
    jump_target  = r.tgt;
    branch_taken = r.br;
    branch_off   = r.off;
  endtask

  // Architectural next-PC rule applied to the model.
  task automatic model_retire(input redir_t r);
    logic [31:0] p4;
    logic [31:0] t;
    p4 = m_pc + 32'd4;
    if (r.exc)       t = EV;
    else if (r.jr)   t = r.jr_addr;
    else if (r.jump) t = {p4[31:28], r.tgt, 2'b00};
    else if (r.br)   t = p4 + r.off * 32'd4;
    else             t = p4;
    if (t % 4 != 0) begin
      t     = EV;
      m_mis = 1'b1;
    end
    m_pc  = t;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    stall = 1'b0;
    drive_redir(no_redir());
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc", pc, RV);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
`ifdef PC_RETIRE_CNT_EN
    check_eq("rst_retire", retire_cnt, 32'd0);
`endif
    rst   = 1'b0;
    m_pc  = RV;
    m_mis = 1'b0;
    m_to  = 1'b0;
    m_ret = '0;
  endtask

  // One instruction: fetch with wait_cyc idle cycles before ack, then stalls, then retire.
  task automatic run_instr(input int wait_cyc, input int stalls, input logic [31:0] word,
                           input redir_t r);
    int n;
    n = 0;
    while (!bus.imem_req && n < 4) begin
      @(negedge clk);
      n++;
    end
    check_eq("fetch_req", 32'(bus.imem_req), 32'd1);
    if (!bus.imem_req) return;
    check_eq("fetch_addr", bus.imem_addr, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int c = 0; c < ATO; c++) begin
      bus.imem_ack   = (c == wait_cyc);
      bus.imem_rdata = (c == wait_cyc) ? word : $urandom;
      stall          = 1'($urandom);
      drive_redir(rand_redir());
      @(negedge clk);
      if (c == wait_cyc) break;
      if (c < ATO - 1) begin
        check_eq("req_held", 32'(bus.imem_req), 32'd1);
        check_eq("addr_held", bus.imem_addr, m_pc);
      end
    end
    bus.imem_ack = 1'b0;
    if (wait_cyc >= ATO) begin
      m_pc = EV;
      m_to = 1'b1;
      check_eq("to_req_drop", 32'(bus.imem_req), 32'd0);
      check_eq("to_pc", pc, m_pc);
      check_eq("to_err", 32'(timeout_err), 32'(m_to));
      return;
    end
    check_eq("exec_valid", 32'(instr_valid), 32'd1);
    check_eq("exec_instr", instr, word);
    check_eq("exec_pc", pc, m_pc);
    check_eq("exec_to_err", 32'(timeout_err), 32'(m_to));
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      drive_redir(rand_redir());
      @(negedge clk);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_pc", pc, m_pc);
      check_eq("stall_instr", instr, word);
    end
    stall = 1'b0;
    drive_redir(r);
    @(negedge clk);
    model_retire(r);
    check_eq("retire_pc", pc, m_pc);
    check_eq("retire_req", 32'(bus.imem_req), 32'd1);
    check_eq("retire_valid", 32'(instr_valid), 32'd0);
    check_eq("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef PC_RETIRE_CNT_EN
    check_eq("retire_cnt", retire_cnt, m_ret);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_t r;
    int     w;
    apply_reset();

    // Zero-wait sequential fetches.
    for (int i = 0; i < 4; i++) run_instr(0, 0, $urandom, no_redir());
    check_eq("t1_seq_pc", pc, 32'h10);

    r = no_redir(); r.br = 1'b1; r.off = -32'sd2;
    run_instr(0, 0, $urandom, r);
    check_eq("t2_branch", pc, 32'h0C);

    r = no_redir(); r.jr = 1'b1; r.jr_addr = 32'h3000_0010;
    run_instr(1, 0, $urandom, r);
    r = no_redir(); r.jump = 1'b1; r.tgt = 26'h0000040;
    run_instr(0, 0, $urandom, r);
    check_eq("t3_jump", pc, 32'h3000_0100);

    r = no_redir(); r.jr = 1'b1; r.jr_addr = 32'hFFFF_FFFC;
    run_instr(0, 0, $urandom, r);
    run_instr(0, 0, $urandom, no_redir());
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_noerr", 32'(misalign_err), 32'd0);

    r = no_redir(); r.jr = 1'b1; r.jr_addr = 32'h0000_0102;
    run_instr(0, 0, $urandom, r);
    check_eq("t4_misalign_pc", pc, EV);
    check_eq("t4_misalign_err", 32'(misalign_err), 32'd1);

    r = no_redir(); r.exc = 1'b1; r.jr = 1'b1; r.jr_addr = 32'h400; r.br = 1'b1; r.off = 32'd5;
    run_instr(0, 0, $urandom, r);
    check_eq("t5_exc_pc", pc, EV);
    check_eq("t4_sticky", 32'(misalign_err), 32'd1);

    apply_reset();
    run_instr(ATO, 0, $urandom, no_redir());
    check_eq("t6_timeout_err", 32'(timeout_err), 32'd1);
    run_instr(0, 0, $urandom, no_redir());
    check_eq("t6_refetch_pc", pc, EV + 32'd4);

    apply_reset();
    run_instr(ATO - 1, 0, $urandom, no_redir());
    check_eq("t6_late_ack_noerr", 32'(timeout_err), 32'd0);

    run_instr(0, 5, $urandom, no_redir());

    // Async reset in the middle of a fetch.
    @(negedge clk);
    check_eq("t7_pre_rst_req", 32'(bus.imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t7_rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("t7_rst_pc", pc, RV);
    @(negedge clk);
    apply_reset();

`ifdef PC_RETIRE_CNT_EN
    run_instr(0, 0, $urandom, no_redir());
    run_instr(0, 1, $urandom, no_redir());
    run_instr(0, 0, $urandom, no_redir());
    check_eq("t8_retire3", retire_cnt, 32'd3);
    apply_reset();
`endif

    for (int i = 0; i < 200; i++) begin
      w = ($urandom_range(0, 19) == 0) ? int'($urandom_range(ATO - 1, ATO + 1))
                                        : int'($urandom_range(0, 3));
      run_instr(w, int'($urandom_range(0, 2)), $urandom, rand_redir());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
